// File: rtl/io_out_bcd_conv_pkg.sv
// Shared definitions for the memory-mapped output port / BCD converter.
//   - default word addresses of the two output ports
//   - converter FSM state encoding
//   - number of double-dabble shift steps per conversion
package io_out_bcd_conv_pkg;

  localparam logic [31:0] PORT1_ADDR_DEF = 32'h0000_0080;
  localparam logic [31:0] PORT2_ADDR_DEF = 32'h0000_0084;

  // One shift per bit of the 32-bit port register.
  localparam int SHIFT_COUNT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/io_out_bcd_conv_bcd_add3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
//   din  : BCD nibble before correction
//   dout : corrected nibble
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/io_out_bcd_conv.sv
// Two memory-mapped 32-bit output ports with a shared serial binary-to-BCD
// converter that shows each port's value mod 100 as two decimal digits.
//   clock, resetn        : clock, synchronous active-low reset
//   addr, datain         : CPU store address / data
//   write_io_enable      : CPU I/O store strobe
//   out_port1, out_port2 : port registers
//   num0..num3           : port 1 ones/tens, port 2 ones/tens
//   busy                 : conversion running or pending
//   done                 : one-cycle pulse after a digit pair update
module io_out_bcd_conv
  import io_out_bcd_conv_pkg::*;
#(
  parameter logic [31:0] PORT1_ADDR = PORT1_ADDR_DEF,
  parameter logic [31:0] PORT2_ADDR = PORT2_ADDR_DEF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        write_io_enable,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2,
  output logic [3:0]  num0,
  output logic [3:0]  num1,
  output logic [3:0]  num2,
  output logic [3:0]  num3,
  output logic        busy,
  output logic        done
);

  state_t      state_reg, state_next;
  logic        pend1_reg, pend2_reg;
  logic        sel2_reg;            // 0: converting port 1, 1: port 2
  logic [31:0] shift_reg;
  logic [7:0]  bcd_reg;
  logic [5:0]  cnt_reg;
  logic        done_reg;
  logic [31:0] port1_reg, port2_reg;
  logic [3:0]  num0_reg, num1_reg, num2_reg, num3_reg;

  logic        load, finish;
  logic        wr1, wr2;
  logic [7:0]  bcd_adj;
  logic [39:0] shifted;

  assign wr1 = write_io_enable && (addr == PORT1_ADDR);
  assign wr2 = write_io_enable && (addr == PORT2_ADDR);

  bcd_add3 u_add3_lo (.din(bcd_reg[3:0]), .dout(bcd_adj[3:0]));
  bcd_add3 u_add3_hi (.din(bcd_reg[7:4]), .dout(bcd_adj[7:4]));

  // The hundreds carry falls off the top, leaving value mod 100.
  assign shifted = {bcd_adj, shift_reg} << 1;

  always_ff @(posedge clock) begin
    if (!resetn) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pend1_reg || pend2_reg) begin
          load       = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_reg == 6'(SHIFT_COUNT - 1)) state_next = ST_DONE;
      end
      ST_DONE: begin
        finish     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      port1_reg <= '0;
      port2_reg <= '0;
      pend1_reg <= 1'b0;
      pend2_reg <= 1'b0;
      sel2_reg  <= 1'b0;
      shift_reg <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      num0_reg  <= '0;
      num1_reg  <= '0;
      num2_reg  <= '0;
      num3_reg  <= '0;
    end else begin
      done_reg <= finish;

      if (wr1) port1_reg <= datain;
      if (wr2) port2_reg <= datain;

      // A store on the same edge as the load re-arms the flag, so the
      // fresh value gets its own conversion.
      if (wr1)                     pend1_reg <= 1'b1;
      else if (load && pend1_reg)  pend1_reg <= 1'b0;
      if (wr2)                     pend2_reg <= 1'b1;
      else if (load && !pend1_reg) pend2_reg <= 1'b0;

      if (load) begin
        sel2_reg  <= !pend1_reg;
        shift_reg <= pend1_reg ? port1_reg : port2_reg;
        bcd_reg   <= '0;
        cnt_reg   <= '0;
      end else if (state_reg == ST_SHIFT) begin
        bcd_reg   <= shifted[39:32];
        shift_reg <= shifted[31:0];
        cnt_reg   <= cnt_reg + 6'd1;
      end

      if (finish) begin
        if (sel2_reg) begin
          num3_reg <= bcd_reg[7:4];
          num2_reg <= bcd_reg[3:0];
        end else begin
          num1_reg <= bcd_reg[7:4];
          num0_reg <= bcd_reg[3:0];
        end
      end
    end
  end

  assign out_port1 = port1_reg;
  assign out_port2 = port2_reg;
  assign num0      = num0_reg;
  assign num1      = num1_reg;
  assign num2      = num2_reg;
  assign num3      = num3_reg;
  assign done      = done_reg;
  assign busy      = (state_reg != ST_IDLE) || pend1_reg || pend2_reg;

endmodule

// File: tb/tb_io_out_bcd_conv.sv
module tb_io_out_bcd_conv;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] datain = '0;
  logic        write_io_enable = 1'b0;
  logic [31:0] out_port1, out_port2;
  logic [3:0]  num0, num1, num2, num3;
  logic        busy, done;

  io_out_bcd_conv dut (
    .clock(clock), .resetn(resetn), .addr(addr), .datain(datain),
    .write_io_enable(write_io_enable), .out_port1(out_port1),
    .out_port2(out_port2), .num0(num0), .num1(num1), .num2(num2),
    .num3(num3), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: port registers and the four displayed digits.
  logic [31:0] m_port [2];
  logic [3:0]  m_dig  [4];   // p1 ones, p1 tens, p2 ones, p2 tens

  function automatic logic [3:0] ones_of(logic [31:0] v);
    return 4'((v % 100) % 10);
  endfunction

  function automatic logic [3:0] tens_of(logic [31:0] v);
    return 4'((v % 100) / 10);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic we);
    addr = a;
    datain = d;
    write_io_enable = we;
    tick();
    if (we && resetn) begin
      if (a == 32'h80) m_port[0] = d;
      if (a == 32'h84) m_port[1] = d;
    end
    write_io_enable = 1'b0;
    addr = '0;
    datain = '0;
    $display("store addr=%08h data=%08h we=%0d", a, d, we);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_port1"}, out_port1, m_port[0]);
    chk({tag, ".out_port2"}, out_port2, m_port[1]);
    chk({tag, ".num0"}, 32'(num0), 32'(m_dig[0]));
    chk({tag, ".num1"}, 32'(num1), 32'(m_dig[1]));
    chk({tag, ".num2"}, 32'(num2), 32'(m_dig[2]));
    chk({tag, ".num3"}, 32'(num3), 32'(m_dig[3]));
  endtask

  task automatic set_digits(input int port, input logic [31:0] v);
    m_dig[port*2]   = ones_of(v);
    m_dig[port*2+1] = tens_of(v);
  endtask

  // Store to an idle converter, then expect the digits exactly 34 edges later.
  task automatic convert_check(input int port, input logic [31:0] v);
    int n;
    logic [31:0] a;
    a = (port == 0) ? 32'h80 : 32'h84;
    store(a, v, 1'b1);
    chk("conv.busy_after_store", 32'(busy), 32'd1);
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      chk("conv.digits_hold", {16'd0, num3, num2, num1, num0},
          {16'd0, m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
      tick();
      n++;
    end
    chk("conv.latency", 32'(n), 32'd34);
    set_digits(port, v);
    check_all("conv");
    tick();
    chk("conv.done_one_cycle", 32'(done), 32'd0);
    chk("conv.busy_idle", 32'(busy), 32'd0);
    $display("convert port%0d value=%0d digits=%0d%0d", port + 1, v,
             m_dig[port*2+1], m_dig[port*2]);
  endtask

  initial begin
    logic [31:0] v;
    int port;
    for (int i = 0; i < 2; i++) m_port[i] = '0;
    for (int i = 0; i < 4; i++) m_dig[i] = '0;

    // Reset state
    resetn = 1'b0;
    tick();
    tick();
    check_all("reset");
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    resetn = 1'b1;
    tick();

    // 1234 to port 1, then all-ones to port 2
    convert_check(0, 32'd1234);
    convert_check(1, 32'hFFFF_FFFF);

    // Back-to-back stores to both ports; port 2 waits for port 1.
    store(32'h80, 32'd7, 1'b1);     // edge 0
    store(32'h84, 32'd42, 1'b1);    // edge 1
    for (int i = 0; i < 33; i++) tick();
    set_digits(0, 32'd7);
    chk("b2b.p1_done", 32'(done), 32'd1);
    check_all("b2b.edge34");
    for (int i = 0; i < 33; i++) tick();
    check_all("b2b.edge67_p2_held");
    tick();
    tick();
    set_digits(1, 32'd42);
    check_all("b2b.edge69");
    chk("b2b.busy_after", 32'(busy), 32'd0);
    $display("back-to-back port1=7 port2=42 digits=%0d%0d %0d%0d", num1, num0, num3, num2);

    // Re-store to port 1 during its own conversion.
    store(32'h80, 32'd56, 1'b1);    // edge 0
    for (int i = 0; i < 9; i++) tick();
    store(32'h80, 32'd89, 1'b1);    // edge 10
    chk("restore.busy", 32'(busy), 32'd1);
    for (int i = 0; i < 24; i++) tick();
    set_digits(0, 32'd56);
    chk("restore.first_done", 32'(done), 32'd1);
    check_all("restore.edge34_old_snapshot");
    for (int i = 0; i < 33; i++) tick();
    check_all("restore.edge67_held");
    tick();
    tick();
    set_digits(0, 32'd89);
    check_all("restore.edge69_fresh");
    chk("restore.busy_after", 32'(busy), 32'd0);
    $display("restore port1 56->89 digits=%0d%0d", num1, num0);

    // Store to an unmapped address, and a disabled store: no effect.
    store(32'h88, 32'd99, 1'b1);
    store(32'h80, 32'd99, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_all("unmapped");
      chk("unmapped.busy", 32'(busy), 32'd0);
      chk("unmapped.done", 32'(done), 32'd0);
      tick();
    end

    // Reset in the middle of a conversion.
    store(32'h80, 32'd12345678, 1'b1);   // edge 0
    tick();                              // load edge, now in SHIFT
    for (int i = 0; i < 10; i++) tick();
    resetn = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) m_port[i] = '0;
    for (int i = 0; i < 4; i++) m_dig[i] = '0;
    check_all("midreset");
    chk("midreset.busy", 32'(busy), 32'd0);
    chk("midreset.done", 32'(done), 32'd0);
    store(32'h84, 32'd5, 1'b1);          // ignored while in reset
    check_all("midreset.store_ignored");
    resetn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("postreset.no_done", 32'(done), 32'd0);
    end
    check_all("postreset");
    chk("postreset.busy", 32'(busy), 32'd0);

    // Randomized conversions with occasional stray stores.
    for (int it = 0; it < 20; it++) begin
      port = int'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: v = 32'd0;
        1: v = 32'hFFFF_FFFF;
        2: v = 32'($urandom_range(0, 199));
        default: v = $urandom;
      endcase
      if ($urandom_range(0, 2) == 0) begin
        store(32'h100 + 32'($urandom_range(0, 63)) * 4, $urandom, 1'b1);
        check_all("rand.stray");
      end
      convert_check(port, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
